// File: rtl/i2c_poll_sequencer.sv
// Autonomous poller for peripheral_i2c: writes a register pointer, repeated-starts,
// reads two bytes from one slave and publishes the 16-bit result.
module i2c_poll_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h40,
    parameter int unsigned PERIOD_CYC  = 1000000,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [7:0]  reg_ptr,
    output logic        i2c_cs,
    output logic [3:0]  i2c_addr,
    output logic        i2c_rd,
    output logic        i2c_wr,
    output logic [15:0] i2c_d_in,
    input  logic [15:0] i2c_d_out,
    output logic        active,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam int PW = $clog2(PERIOD_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, W_SADDR, W_RW0, W_DATA, W_ENA1, POLL_BUSY, W_RW1,
        R_DATA1, W_ENA0, R_DATA2, R_ACK, DONE, ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] per_q;
    logic [TW-1:0] wdog_q;
    logic          phase_q, busy_prev_q;
    logic [1:0]    rise_cnt_q;
    logic [7:0]    ptr_q, byte1_q, byte2_q;
    logic [15:0]   result_q;
    logic          rv_q, err_q;
    logic [1:0]    code_q;

    logic wrap, trig, sample, rise, fall, timeout;
    logic unused_d_out;

    assign unused_d_out = ^i2c_d_out[15:8];
    assign wrap    = en && (per_q == PW'(PERIOD_CYC - 1));
    assign trig    = (state_q == IDLE) && (start || wrap);
    // phase_q=1 is the idle-bus half of POLL_BUSY, where last cycle's busy read lands
    assign sample  = (state_q == POLL_BUSY) && phase_q;
    assign rise    = sample && i2c_d_out[0] && !busy_prev_q;
    assign fall    = sample && !i2c_d_out[0] && busy_prev_q;
    assign timeout = (state_q == POLL_BUSY) && !rise && !fall &&
                     (wdog_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (trig) state_d = W_SADDR;
            W_SADDR:   state_d = W_RW0;
            W_RW0:     state_d = W_DATA;
            W_DATA:    state_d = W_ENA1;
            W_ENA1:    state_d = POLL_BUSY;
            POLL_BUSY: begin
                if (timeout)                           state_d = ABORT;
                else if (rise && rise_cnt_q == 2'd0)   state_d = W_RW1;
                else if (rise && rise_cnt_q == 2'd2)   state_d = R_DATA1;
                else if (fall && rise_cnt_q == 2'd3)   state_d = R_DATA2;
            end
            W_RW1:     state_d = POLL_BUSY;
            R_DATA1:   state_d = W_ENA0;
            W_ENA0:    state_d = POLL_BUSY;
            R_DATA2:   state_d = R_ACK;
            R_ACK:     state_d = DONE;
            DONE:      state_d = IDLE;
            ABORT:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        i2c_cs   = 1'b0;
        i2c_rd   = 1'b0;
        i2c_wr   = 1'b0;
        i2c_addr = 4'h0;
        i2c_d_in = 16'h0;
        unique case (state_q)
            W_SADDR:   begin i2c_cs = 1'b1; i2c_wr = 1'b1; i2c_addr = 4'h4; i2c_d_in = {9'b0, SLAVE_ADDR}; end
            W_RW0:     begin i2c_cs = 1'b1; i2c_wr = 1'b1; i2c_addr = 4'h2; end
            W_DATA:    begin i2c_cs = 1'b1; i2c_wr = 1'b1; i2c_addr = 4'h6; i2c_d_in = {8'b0, ptr_q}; end
            W_ENA1:    begin i2c_cs = 1'b1; i2c_wr = 1'b1; i2c_addr = 4'h0; i2c_d_in = 16'h1; end
            W_RW1:     begin i2c_cs = 1'b1; i2c_wr = 1'b1; i2c_addr = 4'h2; i2c_d_in = 16'h1; end
            W_ENA0,
            ABORT:     begin i2c_cs = 1'b1; i2c_wr = 1'b1; i2c_addr = 4'h0; end
            POLL_BUSY: if (!phase_q) begin i2c_cs = 1'b1; i2c_rd = 1'b1; i2c_addr = 4'h8; end
            R_DATA1,
            R_DATA2:   begin i2c_cs = 1'b1; i2c_rd = 1'b1; i2c_addr = 4'hB; end
            R_ACK:     begin i2c_cs = 1'b1; i2c_rd = 1'b1; i2c_addr = 4'hA; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_q       <= '0;
            wdog_q      <= '0;
            phase_q     <= 1'b0;
            busy_prev_q <= 1'b0;
            rise_cnt_q  <= 2'd0;
            ptr_q       <= 8'h0;
            byte1_q     <= 8'h0;
            byte2_q     <= 8'h0;
            result_q    <= 16'h0;
            rv_q        <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'd0;
        end else begin
            per_q   <= (!en || wrap) ? '0 : per_q + 1'b1;
            phase_q <= (state_q == POLL_BUSY) ? ~phase_q : 1'b0;
            wdog_q  <= (state_q != POLL_BUSY || rise || fall) ? '0 : wdog_q + 1'b1;
            rv_q    <= 1'b0;
            if (sample) busy_prev_q <= i2c_d_out[0];
            if (rise)   rise_cnt_q  <= rise_cnt_q + 2'd1;
            if (trig) begin
                ptr_q       <= reg_ptr;
                rise_cnt_q  <= 2'd0;
                busy_prev_q <= 1'b0;
                if (start) begin
                    err_q  <= 1'b0;
                    code_q <= 2'd0;
                end
            end
            // read data appears one cycle after the read strobe
            if (state_q == W_ENA0) byte1_q <= i2c_d_out[7:0];
            if (state_q == R_ACK)  byte2_q <= i2c_d_out[7:0];
            if (state_q == DONE) begin
                if (i2c_d_out[0]) begin
                    err_q  <= 1'b1;
                    code_q <= 2'd1;
                end else begin
                    result_q <= {byte1_q, byte2_q};
                    rv_q     <= 1'b1;
                end
            end
            if (state_q == ABORT) begin
                err_q  <= 1'b1;
                code_q <= 2'd2;
            end
        end
    end

    assign active       = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = rv_q;
    assign err          = err_q;
    assign err_code     = code_q;
endmodule
